// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_pkg
// Desc     : FSM state type, funct3 access codes and legality helpers.
// Revision : 1.0
// ============================================================================
package mem_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores have no unsigned variants, so only the three signed codes are legal.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr);
        case (f3[1:0])
            2'b01:   return addr[0];
            2'b10:   return (addr != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Desc     : Selects the addressed byte/half of a read word and extends it.
// Revision : 1.0
// ============================================================================
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = rdata_i[{addr_i, 3'b000} +: 8];
    assign w_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_B:    data_o = {{24{w_byte[7]}}, w_byte};
            F3_BU:   data_o = {24'h000000, w_byte};
            F3_H:    data_o = {{16{w_half[15]}}, w_half};
            F3_HU:   data_o = {16'h0000, w_half};
            default: data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Desc     : MEM stage: issues one data-memory access at a time and writes back.
// Revision : 1.0
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [4:0]            rd_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [3:0]            dmem_be_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  wb_valid_o,
    output logic [4:0]            wb_rd_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  fault_o
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            be_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [4:0]            rd_q;
    logic                  wb_valid_q;
    logic [4:0]            wb_rd_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic                  fault_q;

    logic                  w_accept;
    logic                  w_is_mem;
    logic                  w_ok;
    logic                  w_start;
    logic                  w_fault;
    logic                  w_done;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load_data;

    // valid_i is only looked at while idle; in REQ the upstream is stalled.
    assign w_accept = (state_q == ST_IDLE) && valid_i;
    assign w_is_mem = mem_read_i || mem_write_i;
    assign w_ok     = f3_legal(funct3_i, mem_write_i) &&
                      !misaligned(funct3_i, alu_result_i[1:0]);
    assign w_start  = w_accept && w_is_mem && w_ok;
    assign w_fault  = w_accept && w_is_mem && !w_ok;
    assign w_done   = (state_q == ST_REQ) && dmem_ack_i;

    // Replicate store data across all lanes so the memory can pick any lane by be.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = '0;
        if (mem_write_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << alu_result_i[1:0];
                    w_wdata = {4{store_data_i[7:0]}};
                end
                2'b01: begin
                    w_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{store_data_i[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = store_data_i;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_start)    state_d = ST_REQ;
            ST_REQ:  if (dmem_ack_i) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_o    = (state_q == ST_REQ);
        dmem_req_o = (state_q == ST_REQ);
        dmem_we_o  = (state_q == ST_REQ) && we_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 4'b0000;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            fault_q    <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            fault_q    <= w_fault;
            if (w_accept && !w_is_mem) begin
                wb_valid_q <= (rd_i != 5'd0);
                wb_rd_q    <= rd_i;
                wb_data_q  <= alu_result_i;
            end
            if (w_start) begin
                addr_q  <= alu_result_i;
                wdata_q <= w_wdata;
                be_q    <= w_be;
                we_q    <= mem_write_i;
                f3_q    <= funct3_i;
                rd_q    <= rd_i;
            end
            if (w_done && !we_q) begin
                wb_valid_q <= (rd_q != 5'd0);
                wb_rd_q    <= rd_q;
                wb_data_q  <= w_load_data;
            end
        end
    end

    load_extend u_load_extend (
        .rdata_i  (dmem_rdata_i),
        .addr_i   (addr_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (w_load_data)
    );

    assign dmem_addr_o  = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign fault_o      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Desc     : Scoreboard bench with a byte-level memory reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [31:0] alu_result_i, store_data_i;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        fault_o;

    mem_access_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .rd_i(rd_i), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } wb_t;
    typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we; } req_t;

    wb_t  exp_wb[$];
    int   exp_fault[$];
    req_t exp_req[$];

    logic [7:0]  ref_mem [0:1023];
    logic [31:0] rmem    [0:255];

    int tests = 0, fails = 0;
    int force_dly = -1;
    bit force_idle_ack = 1'b0;
    int last_ack_cyc = -10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void preload(input logic [31:0] a, input logic [31:0] w);
        rmem[a[9:2]] = w;
        for (int i = 0; i < 4; i++) ref_mem[int'({a[9:2], 2'b00}) + i] = w[8*i +: 8];
    endfunction

    // Reference: decides every outcome from access size, alignment and byte-addressed memory.
    function automatic void model(input logic rd_, input logic wr_, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] sdata,
                                  input logic [4:0] rd, input int t);
        wb_t w; req_t r; int nb; int off; bit legal; logic [31:0] v;
        if (!rd_ && !wr_) begin
            if (rd != 5'd0) begin w.rd = rd; w.data = addr; w.cyc = t + 1; exp_wb.push_back(w); end
            return;
        end
        legal = wr_ ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) begin exp_fault.push_back(t + 1); return; end
        nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if ((addr % nb) != 0) begin exp_fault.push_back(t + 1); return; end
        off = int'(addr[1:0]);
        r.addr = addr & 32'hFFFF_FFFC;
        if (wr_) begin
            r.be = 4'b0000; r.wdata = '0; r.we = 1'b1;
            for (int k = 0; k < 4; k++) begin
                r.be[k] = (k >= off) && (k < off + nb);
                r.wdata[8*k +: 8] = sdata[8*(k % nb) +: 8];
            end
            for (int i = 0; i < nb; i++) ref_mem[int'(addr[9:0]) + i] = sdata[8*i +: 8];
            exp_req.push_back(r);
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | ({24'h0, ref_mem[int'(addr[9:0]) + i]} << (8*i));
            if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            r.be = 4'b1111; r.wdata = '0; r.we = 1'b0;
            exp_req.push_back(r);
            if (rd != 5'd0) begin w.rd = rd; w.data = v; w.cyc = -1; exp_wb.push_back(w); end
        end
    endfunction

    task automatic garbage();
        valid_i = 1'b0; alu_result_i = $urandom; store_data_i = $urandom;
        mem_read_i = 1'($urandom); mem_write_i = 1'($urandom);
        funct3_i = 3'($urandom); rd_i = 5'($urandom);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; holds the instruction until accepted, returns the accept cycle.
    task automatic issue(input logic rd_, input logic wr_, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         output int t);
        int n;
        valid_i = 1'b1; mem_read_i = rd_; mem_write_i = wr_; funct3_i = f3;
        alu_result_i = alu; store_data_i = sd; rd_i = rd;
        n = 0;
        while (stall_o === 1'b1) begin
            tick(); n++;
            if (n > 100) begin
                $display("FAIL issue_timeout: stall_o high for %0d cycles, expected release", n);
                $fatal(1, "bound expired");
            end
        end
        t = cyc;
        model(rd_, wr_, f3, alu, sd, rd, t);
        tick();
        garbage();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_req"}, 32'(dmem_req_o), 32'd0);
        check({tag, "_we"}, 32'(dmem_we_o), 32'd0);
        check({tag, "_be"}, 32'(dmem_be_o), 32'd0);
        check({tag, "_addr"}, dmem_addr_o, 32'd0);
        check({tag, "_wdata"}, dmem_wdata_o, 32'd0);
        check({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
        check({tag, "_wb_rd"}, 32'(wb_rd_o), 32'd0);
        check({tag, "_wb_data"}, wb_data_o, 32'd0);
        check({tag, "_fault"}, 32'(fault_o), 32'd0);
    endtask

    // Memory responder: checks each REQ cycle against the expected request and acks after a delay.
    initial begin
        req_t r; bit busy; int dly;
        busy = 1'b0; dly = 0;
        dmem_ack_i = 1'b0; dmem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (dmem_req_o === 1'b1) begin
                if (!busy) begin
                    busy = 1'b1;
                    dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
                end
                tests++;
                if (exp_req.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_req: got addr=0x%08h we=%0b, expected no request",
                             dmem_addr_o, dmem_we_o);
                end else begin
                    r = exp_req[0];
                    if (dmem_addr_o !== r.addr || dmem_be_o !== r.be || dmem_we_o !== r.we ||
                        (r.we && dmem_wdata_o !== r.wdata)) begin
                        fails++;
                        $display("FAIL req_fields: got addr=0x%08h be=%b we=%0b wdata=0x%08h, expected addr=0x%08h be=%b we=%0b wdata=0x%08h",
                                 dmem_addr_o, dmem_be_o, dmem_we_o, dmem_wdata_o, r.addr, r.be, r.we, r.wdata);
                    end
                end
                if (dly == 0) begin
                    dmem_ack_i = 1'b1;
                    dmem_rdata_i = rmem[dmem_addr_o[9:2]];
                    if (dmem_we_o)
                        for (int k = 0; k < 4; k++)
                            if (dmem_be_o[k]) rmem[dmem_addr_o[9:2]][8*k +: 8] = dmem_wdata_o[8*k +: 8];
                    if (exp_req.size() > 0) void'(exp_req.pop_front());
                    busy = 1'b0;
                    last_ack_cyc = cyc;
                end else begin
                    dmem_ack_i = 1'b0; dmem_rdata_i = $urandom; dly--;
                end
            end else begin
                if (busy) begin
                    busy = 1'b0;
                    if (exp_req.size() > 0) void'(exp_req.pop_front());
                end
                dmem_ack_i = force_idle_ack || ($urandom_range(0, 3) == 0);
                dmem_rdata_i = $urandom;
            end
        end
    end

    // Writeback and fault monitor.
    initial begin
        wb_t w; int f; int expc;
        forever begin
            @(negedge clk);
            if (wb_valid_o === 1'b1) begin
                tests++;
                if (exp_wb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_wb: got rd=%0d data=0x%08h at cycle %0d, expected none",
                             wb_rd_o, wb_data_o, cyc);
                end else begin
                    w = exp_wb.pop_front();
                    expc = (w.cyc >= 0) ? w.cyc : last_ack_cyc + 1;
                    if (wb_rd_o !== w.rd || wb_data_o !== w.data || cyc != expc) begin
                        fails++;
                        $display("FAIL wb: got rd=%0d data=0x%08h cycle=%0d, expected rd=%0d data=0x%08h cycle=%0d",
                                 wb_rd_o, wb_data_o, cyc, w.rd, w.data, expc);
                    end
                end
            end
            if (fault_o === 1'b1) begin
                tests++;
                if (exp_fault.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_fault: got fault at cycle %0d, expected none", cyc);
                end else begin
                    f = exp_fault.pop_front();
                    if (cyc != f) begin
                        fails++;
                        $display("FAIL fault_cycle: got %0d, expected %0d", cyc, f);
                    end
                end
            end
        end
    end

    initial begin
        int t1, t2, n, nb;
        logic rd_, wr_; logic [2:0] f3; logic [31:0] addr;
        reset = 1'b1;
        garbage();
        for (int i = 0; i < 256; i++) preload(32'(i * 4), $urandom);
        repeat (3) tick();
        check_zero_outputs("reset");
        reset = 1'b0;
        tick();

        // LW with ack on the third REQ cycle.
        preload(32'h100, 32'hDEAD_BEEF);
        force_dly = 2;
        issue(1'b1, 1'b0, 3'b010, 32'h100, $urandom, 5'd5, t1);
        n = 0;
        while (stall_o === 1'b1 && n < 20) begin n++; tick(); end
        check("lw_stall_cycles", 32'(n), 32'd3);
        force_dly = -1;
        repeat (2) tick();

        // LB / LBU from the top byte lane.
        preload(32'h100, 32'h80FF_FFFF);
        issue(1'b1, 1'b0, 3'b000, 32'h103, $urandom, 5'd6, t1);
        issue(1'b1, 1'b0, 3'b100, 32'h103, $urandom, 5'd7, t1);
        issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd8, t1);
        issue(1'b1, 1'b0, 3'b010, 32'h101, $urandom, 5'd9, t1);
        repeat (6) tick();

        // Reset during the second REQ cycle, followed by an ack in IDLE.
        force_dly = 8;
        issue(1'b1, 1'b0, 3'b010, 32'h300, $urandom, 5'd10, t1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        force_idle_ack = 1'b1;
        if (exp_wb.size() > 0) void'(exp_wb.pop_back());
        check_zero_outputs("midreq_reset");
        tick();
        force_idle_ack = 1'b0;
        force_dly = -1;
        check("post_reset_stall", 32'(stall_o), 32'd0);
        repeat (2) tick();

        // Same-cycle ack: load then ADD back to back.
        force_dly = 0;
        issue(1'b1, 1'b0, 3'b010, 32'h040, $urandom, 5'd4, t1);
        issue(1'b0, 1'b0, 3'b000, 32'd7, $urandom, 5'd3, t2);
        check("b2b_accept_gap", 32'(t2 - t1), 32'd2);
        force_dly = -1;
        repeat (3) tick();

        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, 9);
            rd_ = (n >= 3 && n < 6) || n == 9;
            wr_ = (n >= 6);
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            else if (wr_) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nb - 1);
            if (!rd_ && !wr_) addr = $urandom;
            issue(rd_, wr_, f3, addr, $urandom,
                  ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom), t1);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (10) tick();
        check("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
        check("fault_queue_drained", 32'(exp_fault.size()), 32'd0);
        check("req_queue_drained", 32'(exp_req.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid_i  input  1  EX stage presents an instruction this cycle.
REQ-005 alu_result_i  input  32  ALU output; effective address for memory ops, result for others.
REQ-006 store_data_i  input  32  rs2 value for stores.
REQ-007 mem_read_i / mem_write_i  input  1 each  load / store select; both high is treated as a store.
REQ-008 funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 rd_i  input  5  destination register.
REQ-010 stall_o  output  1  upstream holds its outputs stable while high.
REQ-011 dmem_req_o, dmem_we_o  output  1 each  memory request and write strobe.
REQ-012 dmem_addr_o  output  32  word-aligned address, bits [1:0] = 0.
REQ-013 dmem_wdata_o  output  32; dmem_be_o  output  4  lane-replicated write data and byte enables.
REQ-014 dmem_ack_i  input  1; dmem_rdata_i  input  32  completion and read word.
REQ-015 wb_valid_o  output  1; wb_rd_o  output  5; wb_data_o  output  32  registered writeback.
REQ-016 fault_o  output  1  one-cycle pulse for a misaligned or illegal-funct3 access.

Function
REQ-017 The FSM SHALL have the states IDLE and REQ.
REQ-018 In IDLE with valid_i=1: a legal memory op SHALL latch the address, data, funct3, rd and read/write, then go to REQ; a non-memory op SHALL stay in IDLE.
REQ-019 In REQ: dmem_req_o=1 and all dmem_* outputs SHALL hold stable until the cycle dmem_ack_i=1; that cycle is the last REQ cycle, then IDLE.
REQ-020 stall_o SHALL equal (state==REQ), including the ack cycle. valid_i SHALL be sampled only in IDLE.
REQ-021 Non-memory op accepted at cycle T: wb_valid_o=1 at T+1 with wb_data_o=alu_result_i.
REQ-022 Load acked at cycle A: wb_valid_o=1 at A+1 with the extracted and extended data. Stores SHALL never assert wb_valid_o.
REQ-023 rd_i=0 SHALL suppress wb_valid_o. wb_valid_o is a single-cycle pulse per instruction.
REQ-024 Store lanes: byte: be=1<<addr[1:0], wdata={4{b}}. Half: be=addr[1]?1100:0011, wdata={2{h}}. Word: be=1111.
REQ-025 Loads SHALL use dmem_be_o=1111 and dmem_we_o=0.
REQ-026 Load extraction: select the lane by addr[1:0] (byte) or addr[1] (half); funct3[2]=0 sign-extends, funct3[2]=1 zero-extends.
REQ-027 An op SHALL raise fault_o at T+1, issue no request and no writeback, and stay in IDLE when it is:
- a half access with addr[0]=1,
- a word access with addr[1:0]!=0, or
- funct3 011, 110 or 111 (for stores, funct3 other than 000/001/010).
REQ-028 Back-to-back operation SHALL work: an instruction held during REQ SHALL be accepted in the first IDLE cycle, giving a minimum of 2 cycles per memory op when the ack is same-cycle.
REQ-029 dmem_ack_i in IDLE SHALL be ignored.

Reset
REQ-030 Reset SHALL apply on the rising edge while reset=1, at any point including mid-REQ.
REQ-031 Reset values: state=IDLE; stall_o, dmem_req_o, dmem_we_o, wb_valid_o, fault_o = 0; dmem_be_o=0000; dmem_addr_o, dmem_wdata_o, wb_data_o = 0; wb_rd_o=0.
REQ-032 An ack for a request aborted by reset SHALL produce no writeback.

Structure
REQ-033 Package mem_pkg SHALL hold the state enum and the funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
REQ-034 Load lane selection and extension SHALL be a combinational sub-module load_extend (inputs rdata, addr[1:0], funct3; output 32-bit value).

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- LW addr 0x100, ack 3 cycles later with rdata 0xDEADBEEF, rd=5 -> stall_o high 3 cycles, then wb_valid_o with wb_rd_o=5 and wb_data_o=0xDEADBEEF.
- LB addr 0x103, rdata 0x80FF_FF_FF -> wb_data_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x202, data 0x1234ABCD -> dmem_be_o=1100, dmem_wdata_o=0xABCDABCD, dmem_addr_o=0x200, no writeback.
- LW addr 0x101 -> fault_o pulse at T+1, dmem_req_o stays 0, no writeback.
- Reset asserted in the 2nd REQ cycle, ack next cycle -> dmem_req_o=0, stall_o=0, no wb_valid_o.
- Same-cycle ack: load, then ADD result 7 with rd=3 -> load writeback, then ADD writeback one cycle later with wb_data_o=7, never both in the same cycle.
